risc_ctrl: RTL and testbench
============================

RISC_CTRL -- requirements
Module: risc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM-state cycles waiting for mem_ready before a bus error.
REQ-002 SHALL have parameter JALR_IMM_HALT, default 1, meaning JALR with nonzero imm7 halts the core.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instr  input  16  fetched instruction word at the current PC address.
REQ-006 instr_valid  input  1  instr is valid this cycle.
REQ-007 eq  input  1  datapath regA==regB compare result, valid in EXEC.
REQ-008 mem_ready  input  1  data memory has completed the current read or write.
REQ-009 pc_sel  output  2  PC next-value select: 00 PC+1, 01 PC+1+sext(imm7), 10 alu_out, 11 reserved.
REQ-010 pc_en  output  1  PC loads its next value at this edge.
REQ-011 ir_en  output  1  datapath latches instr.
REQ-012 alu_op  output  2  00 add, 01 nand, 10 pass-B, 11 compare.
REQ-013 alu_src_imm  output  1  ALU operand B is sext(imm7).
REQ-014 wb_sel  output  2  writeback source: 00 ALU, 01 memory, 10 PC+1, 11 imm10<<6.
REQ-015 rf_we  output  1  register file write enable.
REQ-016 mem_re / mem_we  output  1 each  data memory read / write request.
REQ-017 halted  output  1  core stopped (HALT or ERR).
REQ-018 bus_err  output  1  memory timeout occurred (sticky).

Function
REQ-019 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT and ERR.
REQ-020 FETCH: ir_en=1; on instr_valid latch opcode=instr[15:13], rega=instr[12:10] and imm7=instr[6:0] into internal IR, then go to DECODE; otherwise stay in FETCH.
REQ-021 DECODE: one cycle, no enables, then go to EXEC.
REQ-022 EXEC for ADD/NAND/ADDI/LUI: drive alu_op and alu_src_imm (ADDI=add+imm, LUI=pass-B), then go to WB.
REQ-023 EXEC for BEQ: alu_op=11, pc_en=1, pc_sel=01 if eq else 00, then go to FETCH; pc_sel SHALL follow eq combinationally in that cycle.
REQ-024 EXEC for JALR with imm7==0: rf_we=1, wb_sel=10, pc_en=1, pc_sel=10, then go to FETCH.
REQ-025 EXEC for JALR with imm7!=0 and JALR_IMM_HALT=1: go to HALT with no PC or RF update; with JALR_IMM_HALT=0, behave as REQ-024.
REQ-026 EXEC for LW/SW: alu_op=00, alu_src_imm=1, then go to MEM.
REQ-027 MEM: mem_re (LW) or mem_we (SW) SHALL be held high continuously until the cycle mem_ready=1; SW then asserts pc_en=1, pc_sel=00 and goes to FETCH; LW goes to WB.
REQ-028 MEM SHALL count wait cycles; when the count reaches MEM_TIMEOUT without mem_ready, it SHALL deassert the request and go to ERR; a mem_ready in the timeout cycle takes priority.
REQ-029 WB: wb_sel per opcode (ALU, memory for LW, imm for LUI), rf_we=1, pc_en=1, pc_sel=00, then go to FETCH.
REQ-030 rf_we SHALL be suppressed whenever rega==0; the PC update is unaffected.
REQ-031 HALT and ERR SHALL be absorbing until rst: halted=1 and all enables 0; ERR additionally sets bus_err=1.
REQ-032 Minimum latencies: ALU op = 4 cycles, BEQ/JALR = 3 cycles, LW = 5 + waits, SW = 4 + waits; pc_en SHALL pulse exactly once per retired instruction.
REQ-033 Outputs not named for a state SHALL be 0 in that state; pc_sel 11 SHALL never be driven.

Reset
REQ-034 rst=1 at any edge SHALL force FETCH, clear IR and the wait counter, and clear halted and bus_err.
REQ-035 While rst=1, all outputs SHALL be 0, including mem_re and mem_we even in MEM.
REQ-036 The first FETCH SHALL occur in the cycle after rst deasserts.

Structure
REQ-037 Package risc16_pkg SHALL hold the opcode constants, pc_sel/wb_sel/alu_op encodings and the state enum.
REQ-038 One sub-module, risc_op_decode, SHALL map opcode and imm7 to combinational class flags (alu, branch, jalr, halt, load, store).

Verification
REQ-039 ADD r1,r2,r3 with instr_valid in FETCH -> EXEC alu_op=00, WB rf_we=1 wb_sel=00 pc_en=1 pc_sel=00; 4 cycles total.
REQ-040 BEQ imm7=7'h7E with eq=1 -> EXEC pc_en=1 pc_sel=01; with eq=0 -> pc_sel=00; 3 cycles each.
REQ-041 LW with mem_ready after 3 wait cycles -> mem_re high for exactly 4 cycles, then WB wb_sel=01 rf_we=1.
REQ-042 SW with mem_ready never asserted, MEM_TIMEOUT=15 -> mem_we high 15 cycles, then ERR with halted=1 bus_err=1; rst clears both.
REQ-043 JALR r0,r1 imm7=1 -> HALT with no pc_en or rf_we; a new instr_valid is ignored.
REQ-044 rst asserted in MEM mid-wait -> mem_re=0 at that edge, FETCH next, no pc_en.

Source files
------------

// File: rtl/risc16_pkg.sv
// +------------------------------------------------------------------+
// | Module      : risc16_pkg                                         |
// | Description : Shared opcode, select encodings, FSM states and    |
// |               instruction class flags for the RiSC-16 controller |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

package risc16_pkg;

    // Opcodes, instr[15:13]
    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_ADDI = 3'b001;
    localparam logic [2:0] c_OP_NAND = 3'b010;
    localparam logic [2:0] c_OP_LUI  = 3'b011;
    localparam logic [2:0] c_OP_SW   = 3'b100;
    localparam logic [2:0] c_OP_LW   = 3'b101;
    localparam logic [2:0] c_OP_BEQ  = 3'b110;
    localparam logic [2:0] c_OP_JALR = 3'b111;

    // PC next-value select (2'b11 is reserved and never driven)
    localparam logic [1:0] c_PC_INC    = 2'b00;
    localparam logic [1:0] c_PC_BRANCH = 2'b01;
    localparam logic [1:0] c_PC_ALU    = 2'b10;

    // Writeback source select
    localparam logic [1:0] c_WB_ALU = 2'b00;
    localparam logic [1:0] c_WB_MEM = 2'b01;
    localparam logic [1:0] c_WB_PC1 = 2'b10;
    localparam logic [1:0] c_WB_IMM = 2'b11;

    // ALU operation select
    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_NAND  = 2'b01;
    localparam logic [1:0] c_ALU_PASSB = 2'b10;
    localparam logic [1:0] c_ALU_CMP   = 2'b11;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // One-hot instruction class produced by the opcode decoder
    typedef struct packed {
        logic alu;
        logic branch;
        logic jalr;
        logic halt;
        logic load;
        logic store;
    } op_class_t;

endpackage

`default_nettype wire

// File: rtl/risc_op_decode.sv
// +------------------------------------------------------------------+
// | Module      : risc_op_decode                                     |
// | Description : Maps the latched opcode and imm7 to instruction    |
// |               class flags used by the controller FSM             |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module risc_op_decode
    import risc16_pkg::*;
#(
    parameter int JALR_IMM_HALT = 1
) (
    input  logic [2:0] i_opcode,
    input  logic [6:0] i_imm7,
    output op_class_t  o_class
);

    // A JALR carrying a nonzero immediate is treated as the halt instruction
    logic w_jalr_halt;
    assign w_jalr_halt = (JALR_IMM_HALT != 0) && (i_imm7 != 7'd0);

    // Exactly one class flag is raised for every opcode
    always_comb begin
        o_class = '0;
        case (i_opcode)
            c_OP_ADD, c_OP_ADDI, c_OP_NAND, c_OP_LUI: o_class.alu = 1'b1;
            c_OP_BEQ:  o_class.branch = 1'b1;
            c_OP_JALR: begin
                o_class.halt = w_jalr_halt;
                o_class.jalr = ~w_jalr_halt;
            end
            c_OP_LW:   o_class.load  = 1'b1;
            c_OP_SW:   o_class.store = 1'b1;
            default:   o_class = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/risc_ctrl.sv
// +------------------------------------------------------------------+
// | Module      : risc_ctrl                                          |
// | Description : Multi-cycle RiSC-16 control FSM: fetch, decode,    |
// |               execute, memory wait with timeout, writeback       |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module risc_ctrl
    import risc16_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 15,
    parameter int JALR_IMM_HALT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic        eq,
    input  logic        mem_ready,
    output logic [1:0]  pc_sel,
    output logic        pc_en,
    output logic        ir_en,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        halted,
    output logic        bus_err
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_opcode;
    logic [2:0]          r_rega;
    logic [6:0]          r_imm7;
    logic [c_WAIT_W-1:0] r_wait;
    op_class_t           w_class;

    logic [1:0] w_pc_sel;
    logic       w_pc_en;
    logic       w_ir_en;
    logic [1:0] w_alu_op;
    logic       w_alu_src_imm;
    logic [1:0] w_wb_sel;
    logic       w_rf_we;
    logic       w_mem_re;
    logic       w_mem_we;
    logic       w_halted;
    logic       w_bus_err;

    // Register operands B/C are consumed by the datapath, not the controller
    logic w_unused_regbc;
    assign w_unused_regbc = ^instr[9:7];

    risc_op_decode #(
        .JALR_IMM_HALT (JALR_IMM_HALT)
    ) u_op_decode (
        .i_opcode (r_opcode),
        .i_imm7   (r_imm7),
        .o_class  (w_class)
    );

    // State, instruction register and memory wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_opcode <= '0;
            r_rega   <= '0;
            r_imm7   <= '0;
            r_wait   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_FETCH && instr_valid) begin
                r_opcode <= instr[15:13];
                r_rega   <= instr[12:10];
                r_imm7   <= instr[6:0];
            end
            if (r_state == ST_MEM && !mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_next_state  = r_state;
        w_pc_sel      = c_PC_INC;
        w_pc_en       = 1'b0;
        w_ir_en       = 1'b0;
        w_alu_op      = c_ALU_ADD;
        w_alu_src_imm = 1'b0;
        w_wb_sel      = c_WB_ALU;
        w_rf_we       = 1'b0;
        w_mem_re      = 1'b0;
        w_mem_we      = 1'b0;
        w_halted      = 1'b0;
        w_bus_err     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_ir_en = 1'b1;
                if (instr_valid) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_class.alu) begin
                    case (r_opcode)
                        c_OP_NAND: w_alu_op = c_ALU_NAND;
                        c_OP_ADDI: w_alu_src_imm = 1'b1;
                        c_OP_LUI: begin
                            w_alu_op      = c_ALU_PASSB;
                            w_alu_src_imm = 1'b1;
                        end
                        default:   w_alu_op = c_ALU_ADD;
                    endcase
                    w_next_state = ST_WB;
                end else if (w_class.branch) begin
                    w_alu_op     = c_ALU_CMP;
                    w_pc_en      = 1'b1;
                    w_pc_sel     = eq ? c_PC_BRANCH : c_PC_INC;
                    w_next_state = ST_FETCH;
                end else if (w_class.jalr) begin
                    w_rf_we      = 1'b1;
                    w_wb_sel     = c_WB_PC1;
                    w_pc_en      = 1'b1;
                    w_pc_sel     = c_PC_ALU;
                    w_next_state = ST_FETCH;
                end else if (w_class.halt) begin
                    w_next_state = ST_HALT;
                end else begin
                    // Load/store: effective address = regB + sext(imm7)
                    w_alu_src_imm = 1'b1;
                    w_next_state  = ST_MEM;
                end
            end
            ST_MEM: begin
                w_mem_re = w_class.load;
                w_mem_we = w_class.store;
                if (mem_ready) begin
                    if (w_class.store) begin
                        w_pc_en      = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_WB: begin
                case (r_opcode)
                    c_OP_LW:  w_wb_sel = c_WB_MEM;
                    c_OP_LUI: w_wb_sel = c_WB_IMM;
                    default:  w_wb_sel = c_WB_ALU;
                endcase
                w_rf_we      = 1'b1;
                w_pc_en      = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            ST_ERR: begin
                w_halted  = 1'b1;
                w_bus_err = 1'b1;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // r0 is hardwired to zero, so its writes are dropped; reset silences everything
    assign pc_sel      = rst ? 2'b00 : w_pc_sel;
    assign pc_en       = ~rst & w_pc_en;
    assign ir_en       = ~rst & w_ir_en;
    assign alu_op      = rst ? 2'b00 : w_alu_op;
    assign alu_src_imm = ~rst & w_alu_src_imm;
    assign wb_sel      = rst ? 2'b00 : w_wb_sel;
    assign rf_we       = ~rst & w_rf_we & (r_rega != 3'd0);
    assign mem_re      = ~rst & w_mem_re;
    assign mem_we      = ~rst & w_mem_we;
    assign halted      = ~rst & w_halted;
    assign bus_err     = ~rst & w_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_risc_ctrl.sv
// +------------------------------------------------------------------+
// | Module      : tb_risc_ctrl                                       |
// | Description : Scoreboard bench for risc_ctrl: directed cases     |
// |               followed by randomized instruction stream          |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_risc_ctrl;
    import risc16_pkg::*;

    localparam int T       = 15;
    localparam int NEVER   = 1000;
    localparam int K_RET   = 0;
    localparam int K_HALT  = 1;
    localparam int K_ERR   = 2;
    localparam int K_ABORT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        eq = 1'b0;
    logic        mem_ready = 1'b0;
    logic [1:0]  pc_sel;
    logic        pc_en;
    logic        ir_en;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic [1:0]  wb_sel;
    logic        rf_we;
    logic        mem_re;
    logic        mem_we;
    logic        halted;
    logic        bus_err;

    always #5 clk = ~clk;

    risc_ctrl #(
        .MEM_TIMEOUT   (T),
        .JALR_IMM_HALT (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .eq          (eq),
        .mem_ready   (mem_ready),
        .pc_sel      (pc_sel),
        .pc_en       (pc_en),
        .ir_en       (ir_en),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .wb_sel      (wb_sel),
        .rf_we       (rf_we),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .halted      (halted),
        .bus_err     (bus_err)
    );

    typedef struct {
        int         op;
        int         kind;
        int         lat;
        int         nre;
        int         nwe;
        int         rf;
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        logic [1:0] alu_op;
        logic       chk_src;
        logic       src;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference model: what one instruction must do, from the ISA-level rules
    function automatic exp_t model(input logic [2:0] op, input logic [2:0] ra,
                                   input logic [6:0] imm, input logic e, input int waits);
        exp_t x;
        int   n;
        x.op = int'(op); x.kind = K_RET; x.lat = 4; x.nre = 0; x.nwe = 0; x.rf = 1;
        x.pc_sel = 2'b00; x.wb_sel = 2'b00; x.alu_op = 2'b00; x.chk_src = 1'b1; x.src = 1'b0;
        case (op)
            c_OP_ADD:  ;
            c_OP_NAND: x.alu_op = 2'b01;
            c_OP_ADDI: x.src = 1'b1;
            c_OP_LUI:  begin x.alu_op = 2'b10; x.wb_sel = 2'b11; x.chk_src = 1'b0; end
            c_OP_BEQ:  begin
                x.lat = 3; x.rf = 0; x.alu_op = 2'b11;
                x.pc_sel = e ? 2'b01 : 2'b00;
            end
            c_OP_JALR: begin
                if (imm != 7'd0) begin
                    x.kind = K_HALT; x.rf = 0;
                end else begin
                    x.lat = 3; x.wb_sel = 2'b10; x.pc_sel = 2'b10;
                end
            end
            default: begin
                x.src = 1'b1;
                if (waits >= T) begin
                    x.kind = K_ERR; x.lat = 3 + T + 1; n = T; x.rf = 0;
                end else begin
                    x.lat = ((op == c_OP_LW) ? 5 : 4) + waits; n = waits + 1;
                    if (op == c_OP_SW) x.rf = 0;
                end
                if (op == c_OP_LW) begin
                    x.nre = n;
                    if (x.kind == K_RET) x.wb_sel = 2'b01;
                end else begin
                    x.nwe = n;
                end
            end
        endcase
        if (ra == 3'd0) x.rf = 0;
        return x;
    endfunction

    // ---------------- monitor ----------------
    int         cyc = 0, issue = 0, nre = 0, nwe = 0, nrf = 0, npc = 0;
    logic [1:0] ex_alu = 2'b00;
    logic       ex_src = 1'b0;
    logic       prev_rst = 1'b1;
    logic       prev_halted = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   gk;
        cyc++;
        if (rst) begin
            chk("outputs all zero during reset",
                int'({pc_sel, pc_en, ir_en, alu_op, alu_src_imm, wb_sel, rf_we,
                      mem_re, mem_we, halted, bus_err}), 0);
            if (q.size() > 0 && q[0].kind == K_ABORT) begin
                e = q.pop_front();
                chk("aborted instr pc_en pulses", npc, 0);
                chk("aborted instr rf_we pulses", nrf, 0);
            end
            nre = 0; nwe = 0; nrf = 0; npc = 0;
            prev_rst = 1'b1;
            prev_halted = 1'b0;
        end else begin
            if (prev_rst)
                chk("first cycle after reset {ir_en,halted,bus_err}",
                    int'({ir_en, halted, bus_err}), 4);
            prev_rst = 1'b0;
            if (ir_en && instr_valid) begin
                issue = cyc; nre = 0; nwe = 0; nrf = 0; npc = 0;
            end
            nre += int'(mem_re);
            nwe += int'(mem_we);
            nrf += int'(rf_we);
            npc += int'(pc_en);
            if (cyc == issue + 2) begin
                ex_alu = alu_op;
                ex_src = alu_src_imm;
            end
            if (pc_en || (halted && !prev_halted)) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected event: pc_en=%0d halted=%0d with nothing outstanding",
                             pc_en, halted);
                end else begin
                    e  = q.pop_front();
                    gk = pc_en ? K_RET : (bus_err ? K_ERR : K_HALT);
                    chk($sformatf("op%0d event kind", e.op), gk, e.kind);
                    chk($sformatf("op%0d latency", e.op), cyc - issue + 1, e.lat);
                    chk($sformatf("op%0d mem_re cycles", e.op), nre, e.nre);
                    chk($sformatf("op%0d mem_we cycles", e.op), nwe, e.nwe);
                    chk($sformatf("op%0d rf_we pulses", e.op), nrf, e.rf);
                    chk($sformatf("op%0d exec alu_op", e.op), int'(ex_alu), int'(e.alu_op));
                    if (e.chk_src)
                        chk($sformatf("op%0d exec alu_src_imm", e.op), int'(ex_src), int'(e.src));
                    if (e.kind == K_RET) begin
                        chk($sformatf("op%0d pc_sel", e.op), int'(pc_sel), int'(e.pc_sel));
                        chk($sformatf("op%0d wb_sel", e.op), int'(wb_sel), int'(e.wb_sel));
                    end
                end
            end
            prev_halted = halted;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [2:0] ra, input logic [6:0] imm,
                             input logic e, input int waits, input int abort_at);
        int   k;
        int   req;
        exp_t x;
        k = 0;
        while (!ir_en && k < 40) begin tick(); k++; end
        if (!ir_en) begin
            n_tests++; n_fail++;
            $display("FAIL fetch wait: ir_en never rose within 40 cycles");
            do_reset(2);
            return;
        end
        repeat ($urandom_range(0, 1)) begin
            instr_valid = 1'b0; instr = 16'($urandom); eq = 1'($urandom);
            mem_ready = 1'($urandom);
            tick();
        end
        x = model(op, ra, imm, e, waits);
        if (abort_at > 0) x.kind = K_ABORT;
        q.push_back(x);
        instr = {op, ra, 3'($urandom_range(0, 7)), imm};
        instr_valid = 1'b1; eq = 1'($urandom); mem_ready = 1'($urandom);
        tick();
        instr_valid = 1'b0; instr = 16'($urandom);
        k = 1; req = 0;
        while (k < 80) begin
            eq = (k == 2) ? e : 1'($urandom);
            if (mem_re || mem_we) begin
                if (abort_at > 0 && req == abort_at) begin
                    rst = 1'b1; mem_ready = 1'b0;
                    tick();
                    rst = 1'b0;
                    return;
                end
                mem_ready = (req == waits);
                req++;
            end else begin
                mem_ready = 1'($urandom);
            end
            tick();
            k++;
            if (ir_en || halted) break;
        end
        if (k >= 80) begin
            n_tests++; n_fail++;
            $display("FAIL instruction timeout: op%0d did not complete in 80 cycles", op);
            do_reset(2);
        end else if (halted) begin
            instr = {c_OP_ADD, 3'd1, 10'd2}; instr_valid = 1'b1;
            repeat (3) tick();
            instr_valid = 1'b0;
            chk("stopped core stays stopped {halted,bus_err}", int'({halted, bus_err}),
                (x.kind == K_ERR) ? 3 : 2);
            do_reset(2);
        end
    endtask

    initial begin
        logic [2:0] op;
        logic [6:0] imm;
        int         w;
        repeat (3) tick();
        rst = 1'b0;
        run_instr(c_OP_ADD,  3'd1, 7'd3,  1'b0, 0, 0);
        run_instr(c_OP_BEQ,  3'd1, 7'h7E, 1'b1, 0, 0);
        run_instr(c_OP_BEQ,  3'd1, 7'h7E, 1'b0, 0, 0);
        run_instr(c_OP_LW,   3'd2, 7'd5,  1'b0, 3, 0);
        run_instr(c_OP_SW,   3'd3, 7'd1,  1'b0, NEVER, 0);
        run_instr(c_OP_JALR, 3'd0, 7'd1,  1'b0, 0, 0);
        run_instr(c_OP_LW,   3'd4, 7'd2,  1'b0, NEVER, 5);
        run_instr(c_OP_ADD,  3'd0, 7'd3,  1'b0, 0, 0);
        run_instr(c_OP_JALR, 3'd5, 7'd0,  1'b0, 0, 0);
        run_instr(c_OP_LW,   3'd1, 7'd0,  1'b0, T - 1, 0);
        run_instr(c_OP_SW,   3'd6, 7'd9,  1'b1, 2, 0);
        run_instr(c_OP_LUI,  3'd7, 7'd4,  1'b0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            op  = 3'($urandom_range(0, 7));
            imm = 7'($urandom);
            if (op == c_OP_JALR && $urandom_range(0, 3) != 0) imm = 7'd0;
            w = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
            run_instr(op, 3'($urandom_range(0, 7)), imm, 1'($urandom), w, 0);
        end
        repeat (5) tick();
        chk("scoreboard entries left over", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire
